// File: rtl/spi_slave.sv
// SPI slave with a 16 x 8 register file: 24-bit frames (ID, ADDR, DATA), write commits
// and read-back over miso. All SPI pins are oversampled on the system clock.
module spi_slave #(
  parameter logic [7:0] SLAVE_IDW = 8'h64,
  parameter logic [7:0] SLAVE_IDR = 8'h65
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [3:0] lcl_addr,
  output logic [7:0] lcl_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_DATA, S_SKIP} state_t;

  state_t      state, next_state;
  logic        ss_meta, ss_sync, ss_prev;
  logic        sck_meta, sck_sync, sck_prev;
  logic        mosi_meta, mosi_sync;
  logic [1:0]  settle;
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [6:0]  rx;
  logic        rw;
  logic [7:0]  addr;
  logic [7:0]  tx;
  logic [7:0]  regs [16];

  logic        sck_rise, sck_fall, ss_fall, ss_rise;
  logic [7:0]  new_byte, load_val;
  logic        start, shift_en, rw_set, rw_val, addr_latch;
  logic        tx_load, tx_shift, oe_set, oe_clr, commit, err;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      ss_meta   <= ss;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign ss_fall  = ~ss_sync & ss_prev;
  assign ss_rise  = ss_sync & ~ss_prev;

  assign new_byte = {rx, mosi_sync};
  assign load_val = (new_byte[7:4] == 4'h0) ? regs[new_byte[3:0]] : 8'h00;

  // The synchronizer reset value fakes ss high; only arm once real ss has been seen high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      if (settle[1] && ss_sync) armed <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    rw_set     = 1'b0;
    rw_val     = 1'b0;
    addr_latch = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    oe_set     = 1'b0;
    oe_clr     = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_fall && armed) begin
          start      = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd7) begin
            if (new_byte == SLAVE_IDW) begin
              rw_set     = 1'b1;
              next_state = S_ADDR;
            end else if (new_byte == SLAVE_IDR) begin
              rw_set     = 1'b1;
              rw_val     = 1'b1;
              next_state = S_ADDR;
            end else begin
              next_state = S_SKIP;
            end
          end
        end
      end
      S_ADDR: begin
        if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd15) begin
            addr_latch = 1'b1;
            next_state = S_DATA;
            if (rw) begin
              tx_load = 1'b1;
              oe_set  = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (sck_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 5'd23) begin
            next_state = S_SKIP;
            oe_clr     = 1'b1;
            commit     = ~rw && (addr[7:4] == 4'h0);
          end
        end else if (sck_fall && rw && bit_cnt > 5'd16) begin
          // The falling edge right after the load keeps bit 7 for the master's first sample
          tx_shift = 1'b1;
        end
      end
      S_SKIP: begin
        oe_clr = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase

    if (ss_rise && state != S_IDLE) begin
      next_state = S_IDLE;
      err        = (state == S_ID) || (state == S_ADDR) || (state == S_DATA);
      shift_en   = 1'b0;
      rw_set     = 1'b0;
      addr_latch = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      oe_set     = 1'b0;
      oe_clr     = 1'b1;
      commit     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= 5'd0;
      rx      <= 7'd0;
      rw      <= 1'b0;
      addr    <= 8'h00;
      tx      <= 8'h00;
      miso_oe <= 1'b0;
    end else begin
      if (start)         bit_cnt <= 5'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 5'd1;
      if (start)         rx <= 7'd0;
      else if (shift_en) rx <= new_byte[6:0];
      if (rw_set)     rw   <= rw_val;
      if (addr_latch) addr <= new_byte;
      if (tx_load)       tx <= load_val;
      else if (tx_shift) tx <= {tx[6:0], 1'b0};
      if (oe_set)      miso_oe <= 1'b1;
      else if (oe_clr) miso_oe <= 1'b0;
    end
  end

  assign miso = miso_oe & tx[7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= commit;
      frame_err <= err;
      if (commit) begin
        regs[addr[3:0]] <= new_byte;
        wr_addr         <= addr;
        wr_data         <= new_byte;
      end
    end
  end

  // Combinational port: a same-cycle commit shows up on the following cycle
  assign lcl_rdata = regs[lcl_addr];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write/read/foreign-ID/out-of-range/abort/reset frames,
// acting as an SPI mode-0 master with a 10-clock sck half-period.
module tb_spi_slave;

  localparam int HP = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ss = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [3:0] lcl_addr = 4'd0;
  logic [7:0] lcl_rdata;
  logic       wr_strobe;
  logic [7:0] wr_addr, wr_data;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;
  int miso_bad = 0;

  logic [7:0] rx, rd;
  bit         oe_pre, oe_data;
  logic [7:0] expect_regs [16];

  spi_slave #(.SLAVE_IDW(8'h64), .SLAVE_IDR(8'h65)) dut (
    .clock(clock), .reset(reset), .ss(ss), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .lcl_addr(lcl_addr), .lcl_rdata(lcl_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
    if (miso_oe) oe_cnt++;
    if (!miso_oe && miso) miso_bad++;
  end

  task automatic wait_clks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr_counts();
    strobe_cnt = 0;
    err_cnt = 0;
    oe_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    lcl_addr = a;
    #1;
    d = lcl_rdata;
  endtask

  task automatic frame(input logic [23:0] word, input int nbits, input bit end_ss,
                       output logic [7:0] data, output bit pre, output bit dat);
    data = 8'h00;
    pre = 1'b0;
    dat = 1'b1;
    ss = 1'b0;
    wait_clks(HP);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[23-i];
      wait_clks(HP);
      if (i >= 16) begin
        data = {data[6:0], miso};
        dat = dat & miso_oe;
      end else begin
        pre = pre | miso_oe;
      end
      sck = 1'b1;
      wait_clks(HP);
      sck = 1'b0;
    end
    mosi = 1'b0;
    wait_clks(HP);
    if (end_ss) begin
      ss = 1'b1;
      wait_clks(4 * HP);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) expect_regs[i] = 8'h00;

    // Reset state
    wait_clks(3);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    read_reg(4'd5, rd);
    check("rst_reg5", rd, 8'h00);
    reset = 1'b0;
    wait_clks(5);

    // Write 0x64,0x05,0xAA
    clr_counts();
    frame(24'h6405AA, 24, 1'b1, rx, oe_pre, oe_data);
    check("wr_strobe_cnt", strobe_cnt, 1);
    check("wr_addr", wr_addr, 8'h05);
    check("wr_data", wr_data, 8'hAA);
    check("wr_no_err", err_cnt, 0);
    check("wr_no_oe", oe_cnt, 0);
    read_reg(4'd5, rd);
    check("wr_reg5", rd, 8'hAA);
    expect_regs[5] = 8'hAA;

    // Read 0x65,0x05
    clr_counts();
    frame(24'h650500, 24, 1'b1, rx, oe_pre, oe_data);
    check("rd_data", rx, 8'hAA);
    check("rd_oe_data", oe_data, 1'b1);
    check("rd_oe_pre", oe_pre, 1'b0);
    check("rd_no_strobe", strobe_cnt, 0);
    check("rd_no_err", err_cnt, 0);
    check("rd_oe_after", miso_oe, 1'b0);

    // Foreign ID 0x70
    clr_counts();
    frame(24'h700555, 24, 1'b1, rx, oe_pre, oe_data);
    check("fid_no_strobe", strobe_cnt, 0);
    check("fid_no_oe", oe_cnt, 0);
    check("fid_no_err", err_cnt, 0);
    read_reg(4'd5, rd);
    check("fid_reg5", rd, 8'hAA);

    // Write to out-of-range address 0x25
    clr_counts();
    frame(24'h642533, 24, 1'b1, rx, oe_pre, oe_data);
    check("oor_no_strobe", strobe_cnt, 0);
    check("oor_no_err", err_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      read_reg(i[3:0], rd);
      check($sformatf("oor_reg%0d", i), rd, expect_regs[i]);
    end

    // Read from out-of-range address 0x25
    clr_counts();
    frame(24'h652500, 24, 1'b1, rx, oe_pre, oe_data);
    check("oor_rd_data", rx, 8'h00);
    check("oor_rd_oe", oe_data, 1'b1);
    check("oor_rd_no_strobe", strobe_cnt, 0);

    // Abort after 12 bits of a write to address 3
    clr_counts();
    frame(24'h6403C3, 12, 1'b1, rx, oe_pre, oe_data);
    check("abort_err", err_cnt, 1);
    check("abort_no_strobe", strobe_cnt, 0);
    read_reg(4'd3, rd);
    check("abort_reg3", rd, 8'h00);

    clr_counts();
    frame(24'h64033C, 24, 1'b1, rx, oe_pre, oe_data);
    check("post_abort_strobe", strobe_cnt, 1);
    check("post_abort_no_err", err_cnt, 0);
    read_reg(4'd3, rd);
    check("post_abort_reg3", rd, 8'h3C);

    // Reset pulse after 20 bits of a write to address 1
    clr_counts();
    frame(24'h6401FF, 20, 1'b0, rx, oe_pre, oe_data);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(5);
    ss = 1'b1;
    wait_clks(4 * HP);
    check("rstmid_no_strobe", strobe_cnt, 0);
    check("rstmid_no_err", err_cnt, 0);
    read_reg(4'd1, rd);
    check("rstmid_reg1", rd, 8'h00);
    read_reg(4'd5, rd);
    check("rstmid_reg5_cleared", rd, 8'h00);

    clr_counts();
    frame(24'h64015A, 24, 1'b1, rx, oe_pre, oe_data);
    check("rstmid_next_strobe", strobe_cnt, 1);
    check("rstmid_next_wr_addr", wr_addr, 8'h01);
    check("rstmid_next_wr_data", wr_data, 8'h5A);
    read_reg(4'd1, rd);
    check("rstmid_next_reg1", rd, 8'h5A);

    check("miso_zero_when_idle", miso_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
